// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the system ID (word 0)
// and build timestamp (word 1) and compares them against build-time values.
// Optional feature macro: SYSID_CHECKER_PERIODIC_EN adds a periodic re-check
// from DONE (parameter PERIOD) and a sticky mismatch_seen output.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'd4919,
  parameter logic [31:0] EXPECTED_TS = 32'd1738763134,
  parameter int          RETRY_LIMIT = 2,
  parameter int          RETRY_GAP   = 16,
  parameter int          TIMEOUT     = 255,
  parameter int          AUTO_START  = 1
`ifdef SYSID_CHECKER_PERIODIC_EN
  ,
  parameter int          PERIOD      = 50_000_000
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [1:0]  attempts,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
`ifdef SYSID_CHECKER_PERIODIC_EN
  ,
  output logic        mismatch_seen
`endif
);

  localparam int STW = $clog2(TIMEOUT + 1);
  localparam int GPW = $clog2(RETRY_GAP + 1);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, GAP, DONE} state_t;

  state_t state_q, state_d;

  logic [STW-1:0] stall_q, stall_d;
  logic [GPW-1:0] gap_q, gap_d;
  logic           busy_q, done_q, pass_q, id_ok_q, ts_ok_q, timeout_q;
  logic [1:0]     attempts_q;
  logic [31:0]    read_id_q, read_ts_q;
  logic           auto_fired_q;

  logic stall_hit, match, retry_ok, gap_end, auto_go, start_run, retry, enter_done;
  logic id_match, ts_match, reload;

  assign id_match  = (read_id_q == EXPECTED_ID);
  assign ts_match  = (read_ts_q == EXPECTED_TS);
  assign match     = id_match && ts_match;
  // The stall counter has seen TIMEOUT-1 stalled cycles; this one is the last.
  assign stall_hit = avm_waitrequest && (stall_q == STW'(TIMEOUT - 1));
  assign retry_ok  = ({1'b0, attempts_q} <= 3'(RETRY_LIMIT));
  assign gap_end   = (gap_q == GPW'(RETRY_GAP - 1));
  assign auto_go   = (AUTO_START != 0) && !auto_fired_q;

`ifdef SYSID_CHECKER_PERIODIC_EN
  localparam int PW = $clog2(PERIOD + 1);
  logic [PW-1:0] per_q, per_d;
  logic          per_hit, periodic_q, mismatch_q;
  assign per_hit = (per_q == PW'(PERIOD - 1));
  assign reload  = start || per_hit;
`else
  assign reload  = start;
`endif

  assign start_run  = (state_q == IDLE || state_q == DONE) && (state_d == RD_ID);
  assign retry      = (state_q == GAP) && (state_d == RD_ID);
  assign enter_done = (state_q != DONE) && (state_d == DONE);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start || auto_go) state_d = RD_ID;
      RD_ID:   if (!avm_waitrequest) state_d = RD_TS;
               else if (stall_hit)   state_d = DONE;
      RD_TS:   if (!avm_waitrequest) state_d = CHECK;
               else if (stall_hit)   state_d = DONE;
      CHECK:   if (match)            state_d = DONE;
               else if (retry_ok)    state_d = GAP;
               else                  state_d = DONE;
      GAP:     if (gap_end)          state_d = RD_ID;
      DONE:    if (reload)           state_d = RD_ID;
      default:                       state_d = IDLE;
    endcase
  end

  // Bus outputs decoded from the registered state so reset drops them at once
  always_comb begin
    avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
    avm_address = (state_q == RD_TS);
  end

  // Counters restart whenever the state changes
  always_comb begin
    stall_d = '0;
    gap_d   = '0;
    if (state_d == state_q) begin
      if (avm_read && avm_waitrequest) stall_d = stall_q + 1'b1;
      if (state_q == GAP)              gap_d   = gap_q + 1'b1;
    end
  end

  // Result, capture and control registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q      <= '0;
      gap_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      id_ok_q      <= 1'b0;
      ts_ok_q      <= 1'b0;
      timeout_q    <= 1'b0;
      attempts_q   <= '0;
      read_id_q    <= '0;
      read_ts_q    <= '0;
      auto_fired_q <= 1'b0;
    end else begin
      stall_q      <= stall_d;
      gap_q        <= gap_d;
      auto_fired_q <= 1'b1;
      if (start_run) begin
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        pass_q     <= 1'b0;
        id_ok_q    <= 1'b0;
        ts_ok_q    <= 1'b0;
        timeout_q  <= 1'b0;
        attempts_q <= 2'd1;
      end
      if (retry) attempts_q <= attempts_q + 1'b1;
      if (enter_done) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
      if (avm_read && stall_hit) timeout_q <= 1'b1;
      if (state_q == RD_ID && !avm_waitrequest) read_id_q <= avm_readdata;
      if (state_q == RD_TS && !avm_waitrequest) read_ts_q <= avm_readdata;
      if (state_q == CHECK) begin
        id_ok_q <= id_match;
        ts_ok_q <= ts_match;
        pass_q  <= match;
      end
    end
  end

`ifdef SYSID_CHECKER_PERIODIC_EN
  always_comb per_d = (state_q == DONE && state_d == DONE) ? per_q + 1'b1 : '0;

  // Periodic re-check tracking; a failing periodic run latches mismatch_seen
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      per_q      <= '0;
      periodic_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      per_q <= per_d;
      if (start_run) periodic_q <= (state_q == DONE) && !start && per_hit;
      if (enter_done && periodic_q && !(state_q == CHECK && match))
        mismatch_q <= 1'b1;
    end
  end
  assign mismatch_seen = mismatch_q;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign attempts = attempts_q;
  assign read_id  = read_id_q;
  assign read_ts  = read_ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: table of slave data patterns plus
// hand-written sequences for latency, retry, timeout, ignored start and reset.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd4919;
  localparam logic [31:0] EXP_TS = 32'd1738763134;

  logic        clk, reset_n, start, wr;
  logic        addr, rd, busy, done, pass, id_ok, ts_ok, tmo;
  logic [1:0]  att;
  logic [31:0] rdata, rid, rts, id_val, ts_val;

  logic        start2, addr2, rd2, busy2, done2, pass2, id_ok2, ts_ok2, tmo2;
  logic [1:0]  att2;
  logic [31:0] rdata2, rid2, rts2;

  int n_total = 0;
  int n_pass  = 0;

  assign rdata  = addr  ? ts_val : id_val;
  assign rdata2 = addr2 ? EXP_TS : EXP_ID;

  sysid_checker u_dut (
    .clock(clk), .reset_n(reset_n), .start(start),
    .avm_address(addr), .avm_read(rd), .avm_waitrequest(wr), .avm_readdata(rdata),
    .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout(tmo), .attempts(att), .read_id(rid), .read_ts(rts)
  );

  sysid_checker #(.AUTO_START(0)) u_idle (
    .clock(clk), .reset_n(reset_n), .start(start2),
    .avm_address(addr2), .avm_read(rd2), .avm_waitrequest(1'b0), .avm_readdata(rdata2),
    .busy(busy2), .done(done2), .pass(pass2), .id_ok(id_ok2), .ts_ok(ts_ok2),
    .timeout(tmo2), .attempts(att2), .read_id(rid2), .read_ts(rts2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        pass;
    logic        id_ok;
    logic        ts_ok;
    int          att;
    int          dcyc;
    int          reads;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Called at the negedge of cycle 1; returns the cycle where done is seen.
  task automatic wait_done(output int c, output int nrd);
    c = 1; nrd = 0;
    while (!done && c < 1000) begin
      if (rd) nrd++;
      @(negedge clk); c++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run(output int c, output int nrd);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(c, nrd);
  endtask

  initial begin
    int c, nrd, idle_act;
    vecs[0] = '{EXP_ID,        EXP_TS,          1'b1, 1'b1, 1'b1, 1, 4,  2};
    vecs[1] = '{EXP_ID,        32'd0,           1'b0, 1'b1, 1'b0, 3, 42, 6};
    vecs[2] = '{32'h8000_1337, EXP_TS,          1'b0, 1'b0, 1'b1, 3, 42, 6};
    vecs[3] = '{32'd0,         32'd0,           1'b0, 1'b0, 1'b0, 3, 42, 6};
    vecs[4] = '{EXP_ID,        EXP_TS ^ 32'd1,  1'b0, 1'b1, 1'b0, 3, 42, 6};
    vecs[5] = '{EXP_ID,        EXP_TS,          1'b1, 1'b1, 1'b1, 1, 4,  2};

    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; wr = 1'b0;
    id_val = EXP_ID; ts_val = EXP_TS;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);   chk("rst_idok", id_ok, 0);
    chk("rst_tsok", ts_ok, 0);  chk("rst_tmo", tmo, 0);
    chk("rst_att", att, 0);     chk("rst_rid", rid, 0);
    chk("rst_rts", rts, 0);     chk("rst_read", rd, 0);

    // Auto start after reset release, no start pulse
    reset_n = 1'b1;
    @(negedge clk);
    chk("auto_read", rd, 1); chk("auto_addr", addr, 0); chk("auto_busy", busy, 1);
    wait_done(c, nrd);
    chk("auto_dcyc", c, 4); chk("auto_pass", pass, 1);

    // AUTO_START=0 instance stays idle until started
    idle_act = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy2 || rd2 || done2) idle_act++;
      @(negedge clk);
    end
    chk("idle_quiet", idle_act, 0);
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    chk("idle2_busy", busy2, 1);
    repeat (3) @(negedge clk);
    chk("idle2_done", done2, 1); chk("idle2_pass", pass2, 1);

    // Cycle-exact latency with no stall
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("lat1_read", rd, 1); chk("lat1_addr", addr, 0);
    chk("lat1_busy", busy, 1); chk("lat1_done", done, 0);
    @(negedge clk);
    chk("lat2_read", rd, 1); chk("lat2_addr", addr, 1);
    @(negedge clk);
    chk("lat3_read", rd, 0); chk("lat3_done", done, 0);
    @(negedge clk);
    chk("lat4_done", done, 1); chk("lat4_pass", pass, 1); chk("lat4_busy", busy, 0);
    chk("lat4_idok", id_ok, 1); chk("lat4_tsok", ts_ok, 1); chk("lat4_att", att, 1);
    chk("lat4_rid", rid, EXP_ID); chk("lat4_rts", rts, EXP_TS);

    // Data patterns
    foreach (vecs[i]) begin
      id_val = vecs[i].id; ts_val = vecs[i].ts;
      run(c, nrd);
      chk($sformatf("v%0d_pass", i), pass, vecs[i].pass);
      chk($sformatf("v%0d_idok", i), id_ok, vecs[i].id_ok);
      chk($sformatf("v%0d_tsok", i), ts_ok, vecs[i].ts_ok);
      chk($sformatf("v%0d_att", i), att, vecs[i].att);
      chk($sformatf("v%0d_dcyc", i), c, vecs[i].dcyc);
      chk($sformatf("v%0d_reads", i), nrd, vecs[i].reads);
      chk($sformatf("v%0d_rid", i), rid, vecs[i].id);
      chk($sformatf("v%0d_rts", i), rts, vecs[i].ts);
      chk($sformatf("v%0d_tmo", i), tmo, 0);
      chk($sformatf("v%0d_busy", i), busy, 0);
    end

    // Mismatch on attempt 1, good data on attempt 2
    id_val = EXP_ID; ts_val = 32'd0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rs_gap_idok", id_ok, 1); chk("rs_gap_tsok", ts_ok, 0); chk("rs_gap_busy", busy, 1);
    ts_val = EXP_TS;
    c = 5;
    while (!done && c < 200) begin @(negedge clk); c++; end
    chk("rs_dcyc", c, 23); chk("rs_pass", pass, 1);
    chk("rs_att", att, 2); chk("rs_tsok", ts_ok, 1);

    // Stall timeout
    wr = 1'b1;
    run(c, nrd);
    chk("to_dcyc", c, 256); chk("to_reads", nrd, 255); chk("to_read_now", rd, 0);
    chk("to_tmo", tmo, 1); chk("to_pass", pass, 0); chk("to_att", att, 1);
    wr = 1'b0;

    // start during RD_TS is ignored
    start = 1'b1; @(negedge clk); start = 1'b0;
    nrd = 0;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 2);
      if (rd) nrd++;
      if (k == 4) chk("ig_done4", done, 1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("ig_reads", nrd, 2); chk("ig_done", done, 1);
    chk("ig_att", att, 1); chk("ig_pass", pass, 1);

    // Reset mid-GAP clears everything immediately
    ts_val = 32'd0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    chk("rg_busy_pre", busy, 1); chk("rg_idok_pre", id_ok, 1);
    reset_n = 1'b0;
    #1;
    chk("rg_busy", busy, 0); chk("rg_done", done, 0); chk("rg_idok", id_ok, 0);
    chk("rg_att", att, 0); chk("rg_rid", rid, 0); chk("rg_read", rd, 0);
    ts_val = EXP_TS;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    wait_done(c, nrd);
    chk("rg_auto_dcyc", c, 4); chk("rg_auto_pass", pass, 1);

    // Reset while a read is stalled drops avm_read asynchronously
    wr = 1'b1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rr_read_pre", rd, 1);
    reset_n = 1'b0;
    #1;
    chk("rr_read", rd, 0); chk("rr_busy", busy, 0);
    wr = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    wait_done(c, nrd);
    chk("rr_auto_pass", pass, 1); chk("rr_auto_att", att, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
